// File: rtl/neuron_cluster_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed neuron cluster.
package neuron_cluster_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StUpdate,
        StEmit
    } state_e;

    // Neuron model select; 2'b1x is reserved and behaves as LIF.
    localparam logic [1:0] ModelLif = 2'b00;
    localparam logic [1:0] ModelIf  = 2'b01;

    // Signed add clamped to a 'width'-bit two's complement range. Operands are
    // sign-extended to 64 bits by the caller, so width must stay well below 64.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        width);
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/neuron_cluster_if.sv
// Spike event stream into the cluster and spike output stream out of it.
interface neuron_cluster_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              in_valid;
    logic [ADDR_W-1:0] in_src;
    logic              in_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready;

    // Router / next-layer side.
    modport master (
        output in_valid, in_src, out_ready,
        input  in_ready, out_valid, out_addr
    );

    // Cluster side.
    modport slave (
        input  in_valid, in_src, out_ready,
        output in_ready, out_valid, out_addr
    );
endinterface

// File: rtl/neuron_cluster_update.sv
// Per-neuron update: leak, integrate, saturate, threshold and refractory hold.
module neuron_update
    import neuron_cluster_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REFR_W     = 2,
    parameter int unsigned REFRACTORY = 2
) (
    input  logic [1:0]               model_i,
    input  logic [3:0]               decay_rate_i,
    input  logic signed [DATA_W-1:0] v_threshold_i,
    input  logic signed [DATA_W-1:0] v_reset_i,
    input  logic signed [DATA_W-1:0] v_cur_i,
    input  logic signed [DATA_W-1:0] acc_cur_i,
    input  logic [REFR_W-1:0]        refr_cur_i,
    output logic signed [DATA_W-1:0] v_next_o,
    output logic [REFR_W-1:0]        refr_next_o,
    output logic                     spike_o
);

    logic signed [DATA_W-1:0] v_decay;
    logic signed [DATA_W-1:0] v_new;

    // Next membrane potential, refractory count and spike decision.
    always_comb begin
        v_decay = v_cur_i;
        // v - (v >>> k) shrinks |v|, so it cannot overflow.
        if (model_i != ModelIf && decay_rate_i != 4'd0) begin
            v_decay = v_cur_i - (v_cur_i >>> decay_rate_i);
        end
        v_new = DATA_W'(sat_add(64'(v_decay), 64'(acc_cur_i), DATA_W));

        v_next_o    = v_new;
        refr_next_o = refr_cur_i;
        spike_o     = 1'b0;
        if (refr_cur_i != '0) begin
            refr_next_o = refr_cur_i - REFR_W'(1);
            v_next_o    = v_reset_i;
        end else if (v_new >= v_threshold_i) begin
            spike_o     = 1'b1;
            v_next_o    = v_reset_i;
            refr_next_o = REFR_W'(REFRACTORY);
        end
    end

endmodule

// File: rtl/neuron_cluster.sv
// Cluster of N_NEURONS spiking neurons sharing one accumulate and one update datapath.
module neuron_cluster
    import neuron_cluster_pkg::*;
#(
    parameter int unsigned       N_NEURONS  = 16,
    parameter int unsigned       FAN_IN     = 4,
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       REFRACTORY = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    localparam int unsigned      IdxW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int unsigned      SlotW      = (FAN_IN > 1) ? $clog2(FAN_IN) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [1:0]               model,
    input  logic signed [DATA_W-1:0] v_threshold,
    input  logic signed [DATA_W-1:0] v_reset,
    input  logic [3:0]               decay_rate,
    input  logic                     cfg_we,
    input  logic [IdxW-1:0]          cfg_neuron,
    input  logic [SlotW-1:0]         cfg_slot,
    input  logic                     cfg_valid,
    input  logic [ADDR_W-1:0]        cfg_src,
    input  logic signed [DATA_W-1:0] cfg_weight,
    output logic                     cfg_ready,
    input  logic                     time_step,
    neuron_cluster_if.slave          spk,
    output logic                     busy,
    output logic                     step_done
);

    localparam int unsigned RefrW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    state_e                   state_q;
    logic [IdxW-1:0]          idx_q;
    logic [ADDR_W-1:0]        src_q;
    logic                     ts_pending_q;
    logic                     out_valid_q;
    logic [ADDR_W-1:0]        out_addr_q;
    logic                     step_done_q;

    logic signed [DATA_W-1:0] v_q    [N_NEURONS];
    logic signed [DATA_W-1:0] acc_q  [N_NEURONS];
    logic [RefrW-1:0]         refr_q [N_NEURONS];

    logic                     slot_valid_q [N_NEURONS][FAN_IN];
    logic [ADDR_W-1:0]        slot_src_q   [N_NEURONS][FAN_IN];
    logic signed [DATA_W-1:0] slot_w_q     [N_NEURONS][FAN_IN];

    logic signed [63:0]       match_sum;
    logic                     idx_last;
    logic signed [DATA_W-1:0] upd_v;
    logic [RefrW-1:0]         upd_refr;
    logic                     upd_spike;

    assign idx_last = (idx_q == IdxW'(N_NEURONS - 1));

    // Exact sum of every valid slot of the current neuron matching the latched source;
    // 64-bit headroom means only the final add into acc needs saturating.
    always_comb begin
        match_sum = '0;
        for (int s = 0; s < FAN_IN; s++) begin
            if (slot_valid_q[idx_q][s] && slot_src_q[idx_q][s] == src_q) begin
                match_sum = match_sum + 64'(slot_w_q[idx_q][s]);
            end
        end
    end

    neuron_update #(
        .DATA_W     (DATA_W),
        .REFR_W     (RefrW),
        .REFRACTORY (REFRACTORY)
    ) u_update (
        .model_i       (model),
        .decay_rate_i  (decay_rate),
        .v_threshold_i (v_threshold),
        .v_reset_i     (v_reset),
        .v_cur_i       (v_q[idx_q]),
        .acc_cur_i     (acc_q[idx_q]),
        .refr_cur_i    (refr_q[idx_q]),
        .v_next_o      (upd_v),
        .refr_next_o   (upd_refr),
        .spike_o       (upd_spike)
    );

    // Control FSM, neuron state, synapse table and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            src_q        <= '0;
            ts_pending_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            step_done_q  <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                v_q[n]    <= '0;
                acc_q[n]  <= '0;
                refr_q[n] <= '0;
                for (int s = 0; s < FAN_IN; s++) begin
                    slot_valid_q[n][s] <= 1'b0;
                    slot_src_q[n][s]   <= '0;
                    slot_w_q[n][s]     <= '0;
                end
            end
        end else begin
            step_done_q <= 1'b0;

            if (cfg_we && state_q == StIdle) begin
                slot_valid_q[cfg_neuron][cfg_slot] <= cfg_valid;
                slot_src_q[cfg_neuron][cfg_slot]   <= cfg_src;
                slot_w_q[cfg_neuron][cfg_slot]     <= cfg_weight;
            end

            unique case (state_q)
                StIdle: begin
                    // A pending or fresh timestep beats a waiting event.
                    if (time_step || ts_pending_q) begin
                        state_q      <= StUpdate;
                        idx_q        <= '0;
                        ts_pending_q <= 1'b0;
                    end else if (spk.in_valid) begin
                        src_q   <= spk.in_src;
                        state_q <= StAccum;
                        idx_q   <= '0;
                    end
                end

                StAccum: begin
                    if (time_step) ts_pending_q <= 1'b1;
                    acc_q[idx_q] <= DATA_W'(sat_add(64'(acc_q[idx_q]), match_sum, DATA_W));
                    if (idx_last) begin
                        state_q <= StIdle;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end

                StUpdate: begin
                    if (time_step) ts_pending_q <= 1'b1;
                    v_q[idx_q]    <= upd_v;
                    refr_q[idx_q] <= upd_refr;
                    acc_q[idx_q]  <= '0;
                    if (upd_spike) begin
                        out_valid_q <= 1'b1;
                        out_addr_q  <= BASE_ADDR + ADDR_W'(idx_q);
                        state_q     <= StEmit;
                    end else if (idx_last) begin
                        step_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end

                StEmit: begin
                    if (time_step) ts_pending_q <= 1'b1;
                    if (spk.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_last) begin
                            step_done_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            idx_q   <= idx_q + IdxW'(1);
                            state_q <= StUpdate;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign spk.in_ready  = (state_q == StIdle) && !time_step && !ts_pending_q;
    assign spk.out_valid = out_valid_q;
    assign spk.out_addr  = out_addr_q;
    assign cfg_ready     = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign step_done     = step_done_q;

endmodule

// File: tb/tb_neuron_cluster.sv
// Self-checking bench for neuron_cluster against a behavioural spike model.
module tb_neuron_cluster;

    localparam int N  = 4;
    localparam int F  = 2;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int R  = 2;
    localparam logic [AW-1:0] BASE = 12'h100;
    localparam longint VMax = 32767;
    localparam longint VMin = -32768;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           model_s;
    logic signed [DW-1:0] th_s;
    logic signed [DW-1:0] vr_s;
    logic [3:0]           dr_s;
    logic                 cfg_we;
    logic [1:0]           cfg_neuron;
    logic [0:0]           cfg_slot;
    logic                 cfg_valid;
    logic [AW-1:0]        cfg_src;
    logic signed [DW-1:0] cfg_weight;
    logic                 cfg_ready;
    logic                 time_step;
    logic                 busy;
    logic                 step_done;

    neuron_cluster_if #(.ADDR_W(AW)) spk ();

    neuron_cluster #(
        .N_NEURONS  (N),
        .FAN_IN     (F),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .REFRACTORY (R),
        .BASE_ADDR  (BASE)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .model       (model_s),
        .v_threshold (th_s),
        .v_reset     (vr_s),
        .decay_rate  (dr_s),
        .cfg_we      (cfg_we),
        .cfg_neuron  (cfg_neuron),
        .cfg_slot    (cfg_slot),
        .cfg_valid   (cfg_valid),
        .cfg_src     (cfg_src),
        .cfg_weight  (cfg_weight),
        .cfg_ready   (cfg_ready),
        .time_step   (time_step),
        .spk         (spk),
        .busy        (busy),
        .step_done   (step_done)
    );

    always #5 clk = ~clk;

    // Reference model state.
    longint m_v[N];
    longint m_acc[N];
    int     m_refr[N];
    bit     m_valid[N][F];
    int     m_src[N][F];
    longint m_w[N][F];
    int     m_mdl;
    int     m_dr;
    longint m_th;
    longint m_vr;
    int     exp_q[$];
    int     got_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x > VMax) return VMax;
        if (x < VMin) return VMin;
        return x;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < N; n++) begin
            m_v[n] = 0; m_acc[n] = 0; m_refr[n] = 0;
            for (int s = 0; s < F; s++) begin
                m_valid[n][s] = 1'b0; m_src[n][s] = 0; m_w[n][s] = 0;
            end
        end
    endfunction

    function automatic void model_event(input int src);
        for (int n = 0; n < N; n++) begin
            longint sum = 0;
            for (int s = 0; s < F; s++)
                if (m_valid[n][s] && m_src[n][s] == src) sum += m_w[n][s];
            m_acc[n] = clamp(m_acc[n] + sum);
        end
    endfunction

    function automatic void model_step();
        exp_q.delete();
        for (int n = 0; n < N; n++) begin
            if (m_refr[n] > 0) begin
                m_refr[n]--;
                m_v[n] = m_vr;
            end else begin
                longint d, vn;
                d  = (m_mdl == 1 || m_dr == 0) ? m_v[n] : m_v[n] - (m_v[n] >>> m_dr);
                vn = clamp(d + m_acc[n]);
                if (vn >= m_th) begin
                    exp_q.push_back(int'(BASE) + n);
                    m_v[n]    = m_vr;
                    m_refr[n] = R;
                end else begin
                    m_v[n] = vn;
                end
            end
            m_acc[n] = 0;
        end
    endfunction

    task automatic set_params(input int mdl, input int dr, input longint th, input longint vr);
        m_mdl = mdl; m_dr = dr; m_th = th; m_vr = vr;
        model_s = 2'(mdl); dr_s = 4'(dr); th_s = DW'(th); vr_s = DW'(vr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int n, input int s, input bit v, input int src,
                             input longint w);
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_neuron = 2'(n); cfg_slot = 1'(s); cfg_valid = v;
        cfg_src = AW'(src); cfg_weight = DW'(w); cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        m_valid[n][s] = v; m_src[n][s] = src; m_w[n][s] = w;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (busy) check("idle_timeout", 0, 1);
    endtask

    // Present one event and wait for its handshake; returns at the negedge after it.
    task automatic offer_event(input int src);
        bit acc = 1'b0;
        int c   = 0;
        spk.in_valid = 1'b1;
        spk.in_src   = AW'(src);
        while (!acc && c < 200) begin
            #1 acc = spk.in_ready;
            @(negedge clk);
            c++;
        end
        spk.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_event(input int src);
        offer_event(src);
        model_event(src);
        wait_idle();
    endtask

    // Run one timestep; hold stalls the first output spike, rnd randomises out_ready.
    task automatic do_step(input int hold, input bit rnd);
        int cyc = 0;
        int stall = 0;
        bit done = 1'b0;
        logic [AW-1:0] held = '0;
        model_step();
        got_q.delete();
        time_step = 1'b1;
        @(negedge clk);
        time_step = 1'b0;
        while (!done && cyc < 300) begin
            cyc++;
            if (spk.out_valid && stall < hold) begin
                spk.out_ready = 1'b0;
                if (stall == 0) held = spk.out_addr;
                else check("hold_addr", spk.out_addr, held);
                check("hold_in_ready", spk.in_ready, 0);
                stall++;
            end else begin
                spk.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (spk.out_valid && spk.out_ready) got_q.push_back(int'(spk.out_addr));
            if (step_done) begin
                done = 1'b1;
                check("done_after_emits", got_q.size(), exp_q.size());
            end else begin
                @(negedge clk);
            end
        end
        spk.out_ready = 1'b1;
        if (!done) check("step_timeout", 0, 1);
        if (!rnd)
            check("step_latency", cyc,
                  N + exp_q.size() + 1 + ((exp_q.size() > 0) ? hold : 0));
        check("spike_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("spike_addr", got_q[i], exp_q[i]);
        @(negedge clk);
        check("step_done_pulse", step_done, 0);
        for (int n = 0; n < N; n++) check($sformatf("v%0d", n), dut.v_q[n], m_v[n]);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; time_step = 1'b0; cfg_we = 1'b0; cfg_neuron = '0; cfg_slot = '0;
        cfg_valid = 1'b0; cfg_src = '0; cfg_weight = '0;
        spk.in_valid = 1'b0; spk.in_src = '0; spk.out_ready = 1'b1;
        set_params(1, 0, 100, 0);
        @(negedge clk);
        do_reset();

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_out_valid", spk.out_valid, 0);
        check("rst_step_done", step_done, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", spk.in_ready, 1);

        // IF neuron 1 fires after two events of weight 60.
        cfg_write(1, 0, 1'b1, 5, 60);
        send_event(5);
        send_event(5);
        do_step(0, 1'b0);

        // Refractory holds two steps, third step fires again.
        for (int k = 0; k < 3; k++) begin
            send_event(5);
            send_event(5);
            do_step(0, 1'b0);
        end

        // LIF leak halves the potential each step.
        do_reset();
        set_params(0, 1, 1000, 0);
        cfg_write(2, 0, 1'b1, 7, 80);
        send_event(7);
        do_step(0, 1'b0);
        do_step(0, 1'b0);
        do_step(0, 1'b0);
        check("lif_v2_final", dut.v_q[2], 20);

        // Saturating accumulate.
        do_reset();
        set_params(1, 0, 32'h7000, 0);
        cfg_write(0, 0, 1'b1, 9, 32'h7FFF);
        for (int k = 0; k < 3; k++) send_event(9);
        check("sat_acc0", dut.acc_q[0], m_acc[0]);
        do_step(0, 1'b0);

        // Back-pressure on two spikes.
        do_reset();
        set_params(1, 0, 100, 0);
        cfg_write(0, 0, 1'b1, 3, 200);
        cfg_write(2, 0, 1'b1, 3, 200);
        send_event(3);
        do_step(10, 1'b0);

        // Event colliding with time_step waits for the next timestep.
        do_reset();
        set_params(1, 0, 100, 0);
        cfg_write(3, 0, 1'b1, 11, 70);
        send_event(11);
        begin
            bit seen = 1'b0;
            bit acc  = 1'b0;
            int c    = 0;
            model_step();
            spk.in_valid = 1'b1; spk.in_src = AW'(11); time_step = 1'b1;
            #1 check("collide_in_ready", spk.in_ready, 0);
            @(negedge clk);
            time_step = 1'b0;
            while (!acc && c < 200) begin
                if (step_done) seen = 1'b1;
                #1 acc = spk.in_ready;
                if (acc) check("accept_after_done", seen, 1);
                @(negedge clk);
                c++;
            end
            spk.in_valid = 1'b0;
            if (!acc) check("collide_timeout", 0, 1);
            model_event(11);
            wait_idle();
            check("collide_v3", dut.v_q[3], m_v[3]);
            check("collide_acc3", dut.acc_q[3], m_acc[3]);
        end
        do_step(0, 1'b0);

        // Randomised configuration, events and back-pressure.
        do_reset();
        set_params(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   longint'($urandom_range(100, 300)), longint'($urandom_range(0, 40)) - 20);
        for (int n = 0; n < N; n++)
            for (int s = 0; s < F; s++)
                cfg_write(n, s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          longint'($urandom_range(0, 120)) - 30);
        for (int it = 0; it < 25; it++) begin
            int nev = int'($urandom_range(0, 3));
            for (int e = 0; e < nev; e++) send_event(int'($urandom_range(0, 3)));
            do_step(int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset in the middle of an accumulate pass.
        do_reset();
        set_params(1, 0, 1000, 0);
        for (int n = 0; n < N; n++) cfg_write(n, 0, 1'b1, 1, 30);
        send_event(1);
        do_step(0, 1'b0);
        offer_event(1);
        check("accum_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", spk.out_valid, 0);
        for (int n = 0; n < N; n++) begin
            check($sformatf("mid_rst_v%0d", n), dut.v_q[n], 0);
            check($sformatf("mid_rst_acc%0d", n), dut.acc_q[n], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        // Slots were cleared, so the same event must not move any neuron.
        send_event(1);
        do_step(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_cluster.md
Name: neuron_cluster

Overview:
- Time-multiplexed cluster of N_NEURONS spiking neurons sharing one accumulate datapath and one update datapath.
- Successor to the single-neuron block: parametrised neuron count, fan-in, data width and refractory period.
- Adds valid/ready spike-event input, a queued spike output, and LIF/IF mode selection.
- Sits between the spike router and the next layer. Arithmetic is signed fixed-point, not float.

Parameters:
- N_NEURONS, 16, neurons in cluster (power of 2, ≥2)
- FAN_IN, 4, synapse slots per neuron
- ADDR_W, 12, spike/neuron address width
- DATA_W, 32, signed weight/potential width
- REFRACTORY, 2, timesteps a neuron is held after spiking (0 = none)
- BASE_ADDR, 0, address of neuron 0

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- model  in  2  00 LIF, 01 IF (no decay), 1x reserved (treated as LIF)
- v_threshold  in  DATA_W  signed firing threshold
- v_reset  in  DATA_W  potential after spike / during refractory
- decay_rate  in  4  LIF leak: v - (v>>>decay_rate); 0 means no leak
- cfg_we  in  1  synapse write strobe
- cfg_neuron  in  log2(N_NEURONS)  target neuron
- cfg_slot  in  log2(FAN_IN)  target slot
- cfg_valid  in  1  slot enable
- cfg_src  in  ADDR_W  source address matched by slot
- cfg_weight  in  DATA_W  signed weight
- cfg_ready  out  1  high in IDLE; writes accepted only then
- in_valid  in  1  input spike present
- in_src  in  ADDR_W  input spike source address
- in_ready  out  1  input accept
- time_step  in  1  one-cycle pulse ending current timestep
- out_valid  out  1  output spike present
- out_addr  out  ADDR_W  BASE_ADDR + neuron index
- out_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- step_done  out  1  one-cycle pulse when update pass finishes

Behaviour:
- Reset:
  - All v, acc and refractory counters cleared to 0; all slots invalid, weights 0.
  - state = IDLE, ts_pending = 0.
  - out_valid = 0, step_done = 0, busy = 0.
  - Reset mid-operation aborts any scan/update immediately; the in-flight output spike is dropped.
- States:
  - IDLE: in_ready = !time_step && !ts_pending.
    - Event handshake (in_valid && in_ready): latch in_src, go to ACCUM, idx = 0.
    - time_step or ts_pending: go to UPDATE, idx = 0, clear ts_pending.
    - A time_step and an event in the same cycle: the time_step wins and the event stays waiting for the next timestep.
  - ACCUM: one neuron per cycle.
    - acc[idx] += sum of weights of all valid slots whose src == latched address. Multiple matching slots all add.
    - Addition saturates to DATA_W signed min/max.
    - After idx = N_NEURONS-1, return to IDLE. Latency: N_NEURONS cycles per event.
    - time_step arriving in ACCUM sets ts_pending; it is never lost.
  - UPDATE: one neuron per cycle.
    - If refr[idx] > 0: refr--, v = v_reset, acc = 0, no spike.
    - Otherwise vn = sat(decay(v) + acc). decay is the identity for IF or decay_rate = 0.
    - If vn >= v_threshold (signed): spike, v = v_reset, refr = REFRACTORY. Otherwise v = vn.
    - acc[idx] = 0 in all cases.
    - Spike: load output register and go to EMIT. Otherwise advance idx.
    - After the last neuron, pulse step_done and go to IDLE.
  - EMIT: out_valid = 1, out_addr stable until out_ready.
    - On handshake, advance idx and return to UPDATE, or finish as above if it was the last neuron.
    - Back-pressure stalls the pass indefinitely. time_step during UPDATE/EMIT sets ts_pending.
- Update pass length: N_NEURONS + (spikes emitted) cycles when out_ready is held high.
- cfg_we outside IDLE is ignored.
- Weight and threshold changes take effect on the next ACCUM/UPDATE cycle that reads them.

Decomposition:
- Package neuron_cluster_pkg: state enum (IDLE, ACCUM, UPDATE, EMIT), model encodings, and a sat_add function (DATA_W-generic signed saturating add).
- Sub-module neuron_update: combinational decay, add, saturate, threshold compare and refractory logic for one neuron. Its outputs are next v, next refr and spike.
- Synapse match adder tree stays inline.

Test Plan:
- Config N=4, FAN_IN=2, DATA_W=16, REFRACTORY=2, model IF.
  - Neuron1 slot0 = (src 5, w 60), threshold 100, v_reset 0.
  - Send src 5 twice, then time_step.
  - Expect one out spike, addr BASE+1. Neuron1 v = 0. step_done 4+1 cycles after the update pass starts.
- LIF, decay_rate 1, v initially 80 (via accumulate, then one step), no input.
  - Expect v = 40 on the next step, then 20, and no spikes.
- Refractory: after the first test's spike, send src 5 twice on each of the next 2 steps.
  - Expect no spikes and v = 0.
  - On the third step with two events, expect a spike again.
- Saturation: weight 0x7FFF with 3 matching events.
  - Expect acc = 0x7FFF with no wrap to negative, and a spike for threshold 0x7000.
- Back-pressure: make neurons 0 and 2 spike and hold out_ready = 0 for 10 cycles.
  - Expect out_addr BASE+0 held stable and in_ready low.
  - Then BASE+2 is emitted in order, and step_done fires only after both handshakes.
- Collision: in_valid and time_step in the same IDLE cycle.
  - Expect the event is not accepted until after step_done and is counted in the next timestep.
- RESET asserted mid-ACCUM: expect all v = 0, busy = 0 and out_valid = 0 on the next cycle.
